// File: rtl/aegnn_hw_commu_model.sv
// Event-driven AEGNN stand-in: per valid event, adds/subtracts (x+y+c) into each FC channel
// PROC_LAT cycles after capture, then tracks the signed argmax; DONE is held while ip_en stays high.
package aegnn_pkg;
   localparam int FC_OUT_WIDTH = 32;
   localparam int COORD_W      = 8;

   typedef struct packed {
      logic               valid;
      logic               p;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [31:0]        t;
      logic [15:0]        addr;
   } event_s;
endpackage

module aegnn_hw_commu_model
   import aegnn_pkg::*;
#(
   parameter int FC_OUT_C = 2,
   parameter int OUT_W    = FC_OUT_WIDTH,
   parameter int PROC_LAT = 2,
   parameter int CNT_W    = 16,
   localparam int PRED_W  = ($clog2(FC_OUT_C) > 1) ? $clog2(FC_OUT_C) : 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      ip_en,
   input  logic                      ip_clean,
   input  event_s                    new_event,
   output logic                      ip_idle,
   output logic                      ip_done,
   output logic [PRED_W-1:0]         prediction,
   output logic [FC_OUT_C*OUT_W-1:0] FC_out,
   output logic [CNT_W-1:0]          event_cnt
);

   localparam int LAT_W = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CLEAN, S_PROC, S_DONE} state_e;

   state_e                         state_q, state_d;
   logic [LAT_W-1:0]               lat_q, lat_d;
   event_s                         ev_q, ev_d;
   logic [FC_OUT_C-1:0][OUT_W-1:0] acc_q, acc_d, acc_upd, delta;
   logic [PRED_W-1:0]              pred_q, pred_d, pred_upd;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           unused_ev;

   // Candidate post-update accumulators and their argmax; only committed on PROC->DONE.
   always_comb begin
      delta    = '0;
      acc_upd  = acc_q;
      pred_upd = '0;
      for (int c = 0; c < FC_OUT_C; c++) begin
         delta[c]   = OUT_W'(ev_q.x) + OUT_W'(ev_q.y) + OUT_W'(c);
         acc_upd[c] = ev_q.p ? acc_q[c] + delta[c] : acc_q[c] - delta[c];
      end
      for (int c = 1; c < FC_OUT_C; c++) begin
         if ($signed(acc_upd[c]) > $signed(acc_upd[pred_upd])) pred_upd = PRED_W'(c);
      end
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      ev_d    = ev_q;
      acc_d   = acc_q;
      pred_d  = pred_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (ip_clean) begin
               state_d = S_CLEAN;
               acc_d   = '0;
               pred_d  = '0;
               cnt_d   = '0;
            end else if (ip_en) begin
               state_d = S_PROC;
               ev_d    = new_event;
               lat_d   = LAT_W'(PROC_LAT - 1);
            end
         end
         S_CLEAN: begin
            acc_d  = '0;
            pred_d = '0;
            cnt_d  = '0;
            if (!ip_clean) state_d = S_IDLE;
         end
         S_PROC: begin
            if (lat_q == '0) begin
               state_d = S_DONE;
               if (ev_q.valid) begin
                  acc_d  = acc_upd;
                  pred_d = pred_upd;
                  cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
               end
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         S_DONE: begin
            if (!ip_en) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         lat_q   <= '0;
         ev_q    <= '0;
         acc_q   <= '0;
         pred_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         ev_q    <= ev_d;
         acc_q   <= acc_d;
         pred_q  <= pred_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ip_idle    = (state_q == S_IDLE);
   assign ip_done    = (state_q == S_DONE);
   assign prediction = pred_q;
   assign FC_out     = acc_q;
   assign event_cnt  = cnt_q;
   assign unused_ev  = ^{ev_q.t, ev_q.addr};

endmodule

// File: tb/tb_aegnn_hw_commu_model.sv
// Bench for aegnn_hw_commu_model: transaction-level model of accumulators, argmax and
// event count; DUT outputs are compared against it on every falling edge.
module tb_aegnn_hw_commu_model;
   localparam int NC  = 2;
   localparam int W   = 32;
   localparam int LAT = 2;
   localparam int CW  = 16;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 ip_en;
   logic                 ip_clean;
   aegnn_pkg::event_s    new_event;
   logic                 ip_idle;
   logic                 ip_done;
   logic [0:0]           prediction;
   logic [NC*W-1:0]      FC_out;
   logic [CW-1:0]        event_cnt;

   aegnn_hw_commu_model #(.FC_OUT_C(NC), .OUT_W(W), .PROC_LAT(LAT), .CNT_W(CW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .ip_en      (ip_en),
      .ip_clean   (ip_clean),
      .new_event  (new_event),
      .ip_idle    (ip_idle),
      .ip_done    (ip_done),
      .prediction (prediction),
      .FC_out     (FC_out),
      .event_cnt  (event_cnt)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic        chk_en = 1'b0;
   logic [W-1:0] exp_acc [NC];
   int          exp_pred;
   int          exp_cnt;
   logic        exp_idle;
   logic        exp_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_zero();
      for (int c = 0; c < NC; c++) exp_acc[c] = '0;
      exp_pred = 0;
      exp_cnt  = 0;
   endtask

   task automatic model_event(input logic p, input logic [7:0] x, input logic [7:0] y);
      logic [W-1:0] d;
      int           best;
      for (int c = 0; c < NC; c++) begin
         d = 32'(x) + 32'(y) + 32'(c);
         exp_acc[c] = p ? exp_acc[c] + d : exp_acc[c] - d;
      end
      best = 0;
      for (int c = 1; c < NC; c++)
         if ($signed(exp_acc[c]) > $signed(exp_acc[best])) best = c;
      exp_pred = best;
      if (exp_cnt != (1 << CW) - 1) exp_cnt++;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("idle", ip_idle, exp_idle);
         check("done", ip_done, exp_done);
         for (int c = 0; c < NC; c++) check("fc_ch", FC_out[c*W +: W], exp_acc[c]);
         check("pred", prediction, exp_pred);
         check("cnt", event_cnt, exp_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_event(output aegnn_pkg::event_s ev);
      ev.valid = 1'($urandom_range(0, 1));
      ev.p     = 1'($urandom_range(0, 1));
      ev.x     = 8'($urandom_range(0, 255));
      ev.y     = 8'($urandom_range(0, 255));
      ev.t     = $urandom;
      ev.addr  = 16'($urandom_range(0, 65535));
   endtask

   // Drives one event end to end; lat = edge count (from first ip_en sample) at which ip_done was seen.
   task automatic run_event(input logic v, input logic p, input logic [7:0] x, input logic [7:0] y,
                            input int hold, output int lat);
      aegnn_pkg::event_s ev;
      aegnn_pkg::event_s junk;
      ev.valid = v;
      ev.p     = p;
      ev.x     = x;
      ev.y     = y;
      ev.t     = $urandom;
      ev.addr  = 16'($urandom_range(0, 65535));
      new_event = ev;
      ip_en     = 1'b1;
      ip_clean  = 1'b0;
      lat       = 0;
      tick();
      exp_idle = 1'b0;
      if (ip_done === 1'b1 && lat == 0) lat = 1;
      for (int i = 1; i <= LAT; i++) begin
         rand_event(junk);
         new_event = junk;
         ip_en     = 1'($urandom_range(0, 1));
         ip_clean  = 1'($urandom_range(0, 1));
         tick();
         if (i == LAT) begin
            if (v) model_event(p, x, y);
            exp_done = 1'b1;
         end
         if (ip_done === 1'b1 && lat == 0) lat = i + 1;
      end
      for (int h = 0; h < hold; h++) begin
         ip_en    = 1'b1;
         ip_clean = 1'($urandom_range(0, 1));
         tick();
      end
      ip_en    = 1'b0;
      ip_clean = 1'($urandom_range(0, 1));
      tick();
      exp_done = 1'b0;
      exp_idle = 1'b1;
      ip_clean = 1'b0;
   endtask

   task automatic run_clean(input logic en, input int hold);
      ip_clean = 1'b1;
      ip_en    = en;
      tick();
      model_zero();
      exp_idle = 1'b0;
      for (int h = 0; h < hold; h++) tick();
      ip_clean = 1'b0;
      ip_en    = 1'b0;
      tick();
      exp_idle = 1'b1;
   endtask

   // Starts a valid event and asserts reset while it is still in flight.
   task automatic run_abort(input int edges_in);
      aegnn_pkg::event_s ev;
      rand_event(ev);
      ev.valid  = 1'b1;
      new_event = ev;
      ip_en     = 1'b1;
      ip_clean  = 1'b0;
      tick();
      exp_idle = 1'b0;
      ip_en    = 1'b0;
      for (int i = 1; i < edges_in; i++) tick();
      #2;
      rstn = 1'b0;
      model_zero();
      exp_idle = 1'b1;
      exp_done = 1'b0;
      #1;
      check("abort_fc", FC_out, 64'd0);
      check("abort_cnt", event_cnt, 64'd0);
      check("abort_idle", ip_idle, 64'd1);
      check("abort_done", ip_done, 64'd0);
      tick();
      rstn = 1'b1;
   endtask

   initial begin
      int lat;
      int r;
      rstn      = 1'b0;
      ip_en     = 1'b0;
      ip_clean  = 1'b0;
      new_event = '0;
      model_zero();
      exp_idle  = 1'b1;
      exp_done  = 1'b0;
      chk_en    = 1'b1;
      #2;
      check("rst_fc", FC_out, 64'd0);
      check("rst_pred", prediction, 64'd0);
      check("rst_cnt", event_cnt, 64'd0);
      check("rst_idle", ip_idle, 64'd1);
      check("rst_done", ip_done, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;

      run_event(1'b1, 1'b1, 8'd3, 8'd4, 1, lat);
      check("ev1_latency", lat, 64'd3);
      check("ev1_ch0", FC_out[31:0], 64'd7);
      check("ev1_ch1", FC_out[63:32], 64'd8);
      check("ev1_pred", prediction, 64'd1);
      check("ev1_cnt", event_cnt, 64'd1);
      check("ev1_idle", ip_idle, 64'd1);

      run_event(1'b1, 1'b0, 8'd10, 8'd0, 0, lat);
      check("ev2_ch0", FC_out[31:0], 64'hFFFF_FFFD);
      check("ev2_ch1", FC_out[63:32], 64'hFFFF_FFFD);
      check("ev2_pred_tie", prediction, 64'd0);
      check("ev2_cnt", event_cnt, 64'd2);

      run_event(1'b0, 1'b1, 8'd55, 8'd66, 2, lat);
      check("inv_latency", lat, 64'd3);
      check("inv_ch0", FC_out[31:0], 64'hFFFF_FFFD);
      check("inv_ch1", FC_out[63:32], 64'hFFFF_FFFD);
      check("inv_cnt", event_cnt, 64'd2);

      ip_clean = 1'b1;
      ip_en    = 1'b1;
      tick();
      model_zero();
      exp_idle = 1'b0;
      check("clean_idle", ip_idle, 64'd0);
      check("clean_done", ip_done, 64'd0);
      check("clean_fc", FC_out, 64'd0);
      check("clean_cnt", event_cnt, 64'd0);
      ip_clean = 1'b0;
      ip_en    = 1'b0;
      tick();
      exp_idle = 1'b1;
      check("clean_exit_idle", ip_idle, 64'd1);

      run_event(1'b1, 1'b1, 8'd9, 8'd9, 0, lat);
      run_abort(2);
      run_event(1'b1, 1'b1, 8'd1, 8'd1, 0, lat);
      check("post_rst_ch0", FC_out[31:0], 64'd2);
      check("post_rst_ch1", FC_out[63:32], 64'd3);
      check("post_rst_cnt", event_cnt, 64'd1);

      for (int k = 0; k < 250; k++) begin
         r = $urandom_range(0, 19);
         if (r < 16)
            run_event(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      $urandom_range(0, 3), lat);
         else if (r < 18)
            run_clean(1'($urandom_range(0, 1)), $urandom_range(0, 2));
         else
            run_abort($urandom_range(1, LAT));
      end

      tick();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, n_err=%0d", n_err);
      $fatal(1);
   end

endmodule
